switches_keys_interface: RTL

Memory-mapped input peripheral for the DE2-115 slide switches and pushbuttons, running in the opposite direction to the 7-segment display output path. It brings the raw asynchronous SW/KEY pins into the clock domain, debounces them with a shared sample tick and latches sticky key-press flags. It presents switch state, key state, press flags and a press counter to the core as 32-bit read words, with write-1-to-clear and an interrupt line.

---
 rtl/switches_keys_interface.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/switches_keys_interface.sv
// Memory-mapped input peripheral for the DE2-115 slide switches and pushbuttons.
// Raw pins are synchronized, debounced on a shared sample tick, and turned into
// switch state, key state, sticky press flags and a press counter readable as
// 32-bit words. Press flags are write-1-to-clear and drive an interrupt line.
module switches_keys_interface #(
    parameter int NUM_SW          = 18,
    parameter int NUM_KEY         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SW-1:0]  SW,
    input  logic [NUM_KEY-1:0] KEY,
    input  logic [1:0]         address,
    input  logic               read_enable,
    input  logic               write_enable,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               key_irq
);

    logic [CNT_WIDTH-1:0] r_prescaler;
    logic [NUM_SW-1:0]    r_swMeta;
    logic [NUM_SW-1:0]    r_swSync;
    logic [NUM_KEY-1:0]   r_keyMeta;
    logic [NUM_KEY-1:0]   r_keySync;
    logic [NUM_SW-1:0]    r_swSample;
    logic [NUM_SW-1:0]    r_swState;
    logic [NUM_KEY-1:0]   r_keySample;
    logic [NUM_KEY-1:0]   r_keyState;
    logic [NUM_KEY-1:0]   r_flags;
    logic [15:0]          r_pressCount;
    logic                 r_irq;
    logic [31:0]          r_readData;

    logic                 w_tick;
    logic [NUM_KEY-1:0]   w_keyPressed;
    logic [NUM_SW-1:0]    w_swStateNext;
    logic [NUM_KEY-1:0]   w_keyStateNext;
    logic [NUM_KEY-1:0]   w_newPress;
    logic [NUM_KEY-1:0]   w_clearMask;
    logic [NUM_KEY-1:0]   w_flagsNext;
    logic [15:0]          w_pressCount;
    logic [31:0]          w_readWord;
    logic                 w_unusedWriteBits;

    // Only the low NUM_KEY bits of the write word carry clear bits; the rest are don't-care.
    assign w_unusedWriteBits = ^write_data;

    // The key synchronizer holds raw pin levels (1 = released), so invert to get pressed = 1.
    assign w_keyPressed = ~r_keySync;

    assign w_tick = (r_prescaler == CNT_WIDTH'(DEBOUNCE_CYCLES - 1));

    // Free-running prescaler that produces the shared debounce sample tick.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prescaler <= '0;
        end else if (w_tick) begin
            r_prescaler <= '0;
        end else begin
            r_prescaler <= r_prescaler + 1'b1;
        end
    end

    // Two-flop synchronizers; key stages come out of reset in the released level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_swMeta  <= '0;
            r_swSync  <= '0;
            r_keyMeta <= '1;
            r_keySync <= '1;
        end else begin
            r_swMeta  <= SW;
            r_swSync  <= r_swMeta;
            r_keyMeta <= KEY;
            r_keySync <= r_keyMeta;
        end
    end

    // A bit's debounced state follows the synchronized value only when two consecutive ticks agree.
    always_comb begin
        w_swStateNext  = r_swState;
        w_keyStateNext = r_keyState;
        if (w_tick) begin
            w_swStateNext  = (r_swSync & ~(r_swSync ^ r_swSample))
                           | (r_swState & (r_swSync ^ r_swSample));
            w_keyStateNext = (w_keyPressed & ~(w_keyPressed ^ r_keySample))
                           | (r_keyState & (w_keyPressed ^ r_keySample));
        end
    end

    // Press events, flag clear mask, next flags and the number of presses this cycle.
    always_comb begin
        w_newPress   = w_keyStateNext & ~r_keyState;
        w_clearMask  = '0;
        if (write_enable && (address == 2'd2)) begin
            w_clearMask = write_data[NUM_KEY-1:0];
        end
        w_flagsNext  = (r_flags & ~w_clearMask) | w_newPress;
        w_pressCount = 16'($countones(w_newPress));
    end

    // Debounce sample and state registers, advanced on the tick.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_swSample  <= '0;
            r_swState   <= '0;
            r_keySample <= '0;
            r_keyState  <= '0;
        end else begin
            if (w_tick) begin
                r_swSample  <= r_swSync;
                r_keySample <= w_keyPressed;
            end
            r_swState  <= w_swStateNext;
            r_keyState <= w_keyStateNext;
        end
    end

    // Sticky press flags (a new press beats a same-cycle clear) and the lagging interrupt.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_flags <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_flags <= w_flagsNext;
            r_irq   <= |r_flags;
        end
    end

    // Wrapping press counter; any write to word 3 reloads it with this cycle's press count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pressCount <= '0;
        end else if (write_enable && (address == 2'd3)) begin
            r_pressCount <= w_pressCount;
        end else begin
            r_pressCount <= r_pressCount + w_pressCount;
        end
    end

    // Read word selection from current (pre-write) register values.
    always_comb begin
        w_readWord = '0;
        case (address)
            2'd0:    w_readWord = 32'(r_swState);
            2'd1:    w_readWord = 32'(r_keyState);
            2'd2:    w_readWord = 32'(r_flags);
            default: w_readWord = {16'b0, r_pressCount};
        endcase
    end

    // Registered read data that holds its value between read strobes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_readData <= '0;
        end else if (read_enable) begin
            r_readData <= w_readWord;
        end
    end

    assign read_data = r_readData;
    assign key_irq   = r_irq;

endmodule
